// File: rtl/hard_activation_unit.sv
// Multi-lane hard activation pipeline: bypass, ReLU, ReLU6, h-sigmoid and h-swish on signed
// fixed-point samples. Three register stages with a single elastic stall driven by out_ready.
module hard_activation_unit #(
  parameter int INT_BITS  = 16,
  parameter int FRAC_BITS = 16,
  parameter int LANES     = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [2:0]                              mode,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [LANES*(INT_BITS+FRAC_BITS)-1:0]   in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [LANES*(INT_BITS+FRAC_BITS)-1:0]   out_data,
  output logic [LANES-1:0]                        out_clip,
  input  logic                                    clr_count,
  output logic [15:0]                             clip_count
);

  localparam int DW  = INT_BITS + FRAC_BITS;
  localparam int EW  = DW + 3;          // x + 3.0 without wrap
  localparam int CW  = FRAC_BITS + 3;   // clamped offset, range [0, 6.0]
  localparam int HW  = FRAC_BITS + 1;   // h-sigmoid, range [0, 1.0]
  localparam int PW2 = CW + FRAC_BITS;
  localparam int PW3 = DW + HW + 1;

  localparam logic [2:0] MODE_RELU   = 3'd1;
  localparam logic [2:0] MODE_RELU6  = 3'd2;
  localparam logic [2:0] MODE_HSIG   = 3'd3;
  localparam logic [2:0] MODE_HSWISH = 3'd4;

  localparam logic signed [EW-1:0]  THREE_E = EW'(3) << FRAC_BITS;
  localparam logic signed [EW-1:0]  SIX_E   = EW'(6) << FRAC_BITS;
  localparam logic [CW-1:0]         SIX_C   = CW'(6) << FRAC_BITS;
  localparam logic signed [DW-1:0]  SIX_X   = DW'(6) << FRAC_BITS;
  localparam logic [CW-1:0]         ONE_Y   = CW'(1) << FRAC_BITS;
  localparam logic [HW-1:0]         ONE_H   = HW'(1) << FRAC_BITS;
  localparam logic [PW2-1:0]        HALF2   = PW2'(1) << (FRAC_BITS - 1);
  localparam logic signed [PW3-1:0] HALF3   = PW3'(1) << (FRAC_BITS - 1);
  localparam logic signed [PW3-1:0] MAX3    = (PW3'(1) << (DW - 1)) - PW3'(1);
  localparam logic signed [PW3-1:0] MIN3    = -(PW3'(1) << (DW - 1));
  // Reciprocal of 6 rounded to nearest
  localparam logic [FRAC_BITS-1:0]  K       = FRAC_BITS'(((1 << FRAC_BITS) + 3) / 6);

  function automatic logic [CW-1:0] offset_clamp(input logic signed [DW-1:0] x);
    logic signed [EW-1:0] sum;
    logic [CW-1:0]        c;
    sum = {{3{x[DW-1]}}, x} + THREE_E;
    if (sum[EW-1])       c = '0;
    else if (sum > SIX_E) c = SIX_C;
    else                  c = sum[CW-1:0];
    return c;
  endfunction

  // Returns {clip, hs}
  function automatic logic [HW:0] hsig(input logic [CW-1:0] c);
    logic [PW2-1:0] prod;
    logic [CW-1:0]  y;
    logic [HW:0]    res;
    prod = PW2'(c) * PW2'(K) + HALF2;
    y    = CW'(prod >> FRAC_BITS);
    if (y > ONE_Y) res = {1'b1, ONE_H};
    else           res = {1'b0, y[HW-1:0]};
    return res;
  endfunction

  // Returns {clip, y}
  function automatic logic [DW:0] stage3(input logic [2:0]           m,
                                         input logic signed [DW-1:0] x,
                                         input logic [HW-1:0]        hs,
                                         input logic                 hclip);
    logic signed [PW3-1:0] xe;
    logic signed [PW3-1:0] he;
    logic signed [PW3-1:0] rnd;
    logic [DW:0]           res;
    xe  = {{(PW3-DW){x[DW-1]}}, x};
    he  = {{(PW3-HW){1'b0}}, hs};
    rnd = (xe * he + HALF3) >>> FRAC_BITS;
    res = {1'b0, x};
    case (m)
      MODE_RELU:   res = x[DW-1] ? '0 : {1'b0, x};
      MODE_RELU6: begin
        if (x[DW-1])       res = '0;
        else if (x > SIX_X) res = {1'b1, SIX_X};
        else                res = {1'b0, x};
      end
      MODE_HSIG:   res = {hclip, {(DW-HW){1'b0}}, hs};
      MODE_HSWISH: begin
        if (rnd > MAX3)      res = {1'b1, MAX3[DW-1:0]};
        else if (rnd < MIN3) res = {1'b1, MIN3[DW-1:0]};
        else                 res = {1'b0, rnd[DW-1:0]};
      end
      default:     res = {1'b0, x};
    endcase
    return res;
  endfunction

  logic                 s1_valid_q;
  logic [2:0]           s1_mode_q;
  logic [DW-1:0]        s1_x_q   [LANES];
  logic [CW-1:0]        s1_c_q   [LANES];
  logic                 s2_valid_q;
  logic [2:0]           s2_mode_q;
  logic [DW-1:0]        s2_x_q   [LANES];
  logic [HW-1:0]        s2_hs_q  [LANES];
  logic [LANES-1:0]     s2_hclip_q;
  logic                 out_valid_q;
  logic [LANES*DW-1:0]  out_data_q;
  logic [LANES-1:0]     out_clip_q;
  logic [15:0]          clip_count_q;

  logic [CW-1:0]        s1_c_d   [LANES];
  logic [HW-1:0]        s2_hs_d  [LANES];
  logic [LANES-1:0]     s2_hclip_d;
  logic [LANES*DW-1:0]  out_data_d;
  logic [LANES-1:0]     out_clip_d;
  logic                 advance;

  // Valid/ready: a beat moves on any edge where valid && ready; the output beat and its
  // data hold unchanged while out_valid && !out_ready, and then every stage holds too.
  assign advance    = !out_valid_q || out_ready;
  assign in_ready   = advance;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_clip   = out_clip_q;
  assign clip_count = clip_count_q;

  always_comb begin
    s1_c_d     = '{default: '0};
    s2_hs_d    = '{default: '0};
    s2_hclip_d = '0;
    out_data_d = '0;
    out_clip_d = '0;
    for (int l = 0; l < LANES; l++) begin
      s1_c_d[l] = offset_clamp(in_data[l*DW +: DW]);
      {s2_hclip_d[l], s2_hs_d[l]} = hsig(s1_c_q[l]);
      {out_clip_d[l], out_data_d[l*DW +: DW]} =
        stage3(s2_mode_q, s2_x_q[l], s2_hs_q[l], s2_hclip_q[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= '0;
      s2_hclip_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_clip_q  <= '0;
      for (int l = 0; l < LANES; l++) begin
        s1_x_q[l]  <= '0;
        s1_c_q[l]  <= '0;
        s2_x_q[l]  <= '0;
        s2_hs_q[l] <= '0;
      end
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s1_mode_q   <= mode;
      s2_valid_q  <= s1_valid_q;
      s2_mode_q   <= s1_mode_q;
      s2_hclip_q  <= s2_hclip_d;
      out_valid_q <= s2_valid_q;
      out_data_q  <= out_data_d;
      out_clip_q  <= out_clip_d;
      for (int l = 0; l < LANES; l++) begin
        s1_x_q[l]  <= in_data[l*DW +: DW];
        s1_c_q[l]  <= s1_c_d[l];
        s2_x_q[l]  <= s1_x_q[l];
        s2_hs_q[l] <= s2_hs_d[l];
      end
    end
  end

  // Clear wins over a simultaneous clipped handshake
  always_ff @(posedge clk) begin
    if (!rst_n || clr_count) begin
      clip_count_q <= '0;
    end else if (out_valid_q && out_ready && (|out_clip_q) && (clip_count_q != 16'hFFFF)) begin
      clip_count_q <= clip_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_hard_activation_unit.sv
// Bench for hard_activation_unit (Q16.16, 4 lanes): arithmetic reference model, expected-beat
// queue checked on every cycle, directed literal beats, random stall stream, reset and counter cases.
module tb_hard_activation_unit;

  localparam int LANES    = 4;
  localparam int DW       = 32;
  localparam int W        = LANES*DW + LANES;
  localparam int CLK_HALF = 5;

  localparam longint ONE     = 65536;
  localparam longint K_RECIP = 10923;  // round(65536 / 6)
  localparam longint SMAX    = 2147483647;
  localparam longint SMIN    = -SMAX - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          mode;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [LANES*DW-1:0] out_data;
  logic [LANES-1:0]    out_clip;
  logic                clr_count;
  logic [15:0]         clip_count;

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  bit          started = 1'b0;
  bit          prev_stall = 1'b0;
  logic [W-1:0] head;

  // ---------------- clock ----------------
  always #CLK_HALF clk = ~clk;

  hard_activation_unit #(
    .INT_BITS (16),
    .FRAC_BITS(16),
    .LANES    (LANES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_clip  (out_clip),
    .clr_count (clr_count),
    .clip_count(clip_count)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {clip, y} for one lane
  function automatic logic [DW:0] lane_model(input logic [2:0] m, input logic [DW-1:0] xb);
    longint x, c, y, hs, r;
    logic hclip;
    logic [DW:0] res;
    x = longint'($signed(xb));
    c = x + 3*ONE;
    if (c < 0) c = 0;
    if (c > 6*ONE) c = 6*ONE;
    y = (c*K_RECIP + ONE/2) / ONE;
    hclip = (y > ONE);
    hs = hclip ? ONE : y;
    r = (x*hs + ONE/2) >>> 16;
    case (m)
      3'd1: res = (x < 0) ? '0 : {1'b0, xb};
      3'd2: begin
        if (x < 0)          res = '0;
        else if (x > 6*ONE) res = {1'b1, 32'h0006_0000};
        else                res = {1'b0, xb};
      end
      3'd3: res = {hclip, hs[31:0]};
      3'd4: begin
        if (r > SMAX)      res = {1'b1, 32'h7FFF_FFFF};
        else if (r < SMIN) res = {1'b1, 32'h8000_0000};
        else               res = {1'b0, r[31:0]};
      end
      default: res = {1'b0, xb};
    endcase
    return res;
  endfunction

  function automatic logic [W-1:0] beat_model(input logic [2:0] m, input logic [LANES*DW-1:0] d);
    logic [LANES*DW-1:0] dd;
    logic [LANES-1:0]    cc;
    logic [DW:0]         t;
    for (int l = 0; l < LANES; l++) begin
      t = lane_model(m, d[l*DW +: DW]);
      dd[l*DW +: DW] = t[DW-1:0];
      cc[l] = t[DW];
    end
    return {cc, dd};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      check("clip_count", clip_count, exp_cnt);
      if (!rst_n) begin
        exp_q.delete();
        exp_cnt    = 16'd0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("stall_hold_valid", out_valid, 1'b1);
        if (exp_q.size() == 0) begin
          check("no_beat_expected", out_valid, 1'b0);
        end else if (out_valid) begin
          head = exp_q[0];
          check("beat", {out_clip, out_data}, head);
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (!clr_count && (|head[W-1 -: LANES]) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
          end
        end
        if (clr_count) exp_cnt = 16'd0;
        if (in_valid && in_ready) exp_q.push_back(beat_model(mode, in_data));
        prev_stall = out_valid && !out_ready;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] rand_sample();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom();
      1: v = 32'($urandom_range(0, 20*65536)) - 32'(10*65536);
      2: begin
        case ($urandom_range(0, 5))
          0: v = 32'h0006_0000;
          1: v = 32'h0003_0000;
          2: v = 32'hFFFD_0000;
          3: v = 32'h7FFF_FFFF;
          4: v = 32'h8000_0000;
          default: v = 32'h0000_0000;
        endcase
      end
      default: v = 32'($urandom_range(0, 8*65536)) - 32'(4*65536);
    endcase
    return v;
  endfunction

  // One beat with out_ready high; checks 3-cycle latency and literal results
  task automatic directed(input string name, input logic [2:0] m, input logic [LANES*DW-1:0] din,
                          input logic [LANES*DW-1:0] dreq, input logic [LANES-1:0] creq);
    @(posedge clk); #1;
    mode = m; in_data = din; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); check({name, "_lat1"}, out_valid, 1'b0);
    @(negedge clk); check({name, "_lat2"}, out_valid, 1'b0);
    @(negedge clk); check({name, "_lat3"}, out_valid, 1'b1);
    check({name, "_data"}, out_data, dreq);
    check({name, "_clip"}, out_clip, creq);
  endtask

  task automatic drain(input string name);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (!in_valid || in_ready) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic run_stream(input int ncyc);
    bit acc;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 4) != 0);
        mode = mode + 3'($urandom_range(1, 7));
        for (int l = 0; l < LANES; l++) in_data[l*DW +: DW] = rand_sample();
      end
    end
    drain("stream");
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(CLK_HALF*2*90000);
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; mode = 3'd0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; clr_count = 1'b0;

    check("model_relu6_7p3125", lane_model(3'd2, 32'h0007_5000), {1'b1, 32'h0006_0000});
    check("model_hsig_4", lane_model(3'd3, 32'h0004_0000), {1'b1, 32'h0001_0000});
    check("model_hsig_0", lane_model(3'd3, 32'h0000_0000), {1'b0, 32'h0000_8001});
    check("model_hswish_m1", lane_model(3'd4, 32'hFFFF_0000), {1'b0, 32'hFFFF_AAAA});

    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; started = 1'b1;
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, '0);
    check("reset_out_clip", out_clip, '0);
    check("reset_clip_count", clip_count, 16'd0);
    check("reset_in_ready", in_ready, 1'b1);

    directed("relu", 3'd1,
             {32'h0001_8001, 32'h8000_0000, 32'hFFFF_0000, 32'h0000_FFFF},
             {32'h0001_8001, 32'h0000_0000, 32'h0000_0000, 32'h0000_FFFF}, 4'b0000);
    directed("relu6", 3'd2,
             {32'hFFFF_8000, 32'h0002_8000, 32'h0006_0000, 32'h0007_5000},
             {32'h0000_0000, 32'h0002_8000, 32'h0006_0000, 32'h0006_0000}, 4'b0001);
    @(negedge clk); check("relu6_clip_count", clip_count, 16'd1);
    directed("hsig", 3'd3,
             {32'h7FFF_0000, 32'h0003_0000, 32'hFFFC_0000, 32'h0004_0000},
             {32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000}, 4'b1101);
    directed("hswish", 3'd4,
             {32'h7FFF_0000, 32'h0003_0000, 32'hFFFC_0000, 32'h0004_0000},
             {32'h7FFF_0000, 32'h0003_0000, 32'h0000_0000, 32'h0004_0000}, 4'b0000);
    directed("mode7", 3'd7,
             {32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678},
             {32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678}, 4'b0000);

    run_stream(600);

    // Reset with three beats in flight and the output stalled
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; mode = 3'd2; in_data = {4{32'h0007_0000}};
    repeat (3) @(posedge clk);
    #1; in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("pre_rst_out_valid", out_valid, 1'b1);
    check("pre_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_clip_count", clip_count, 16'd0);
    check("rst_mid_in_ready", in_ready, 1'b1);
    repeat (6) @(negedge clk);
    directed("post_rst_mode5", 3'd5,
             {32'h0006_0001, 32'hFFFD_0000, 32'h8000_0000, 32'h1234_5678},
             {32'h0006_0001, 32'hFFFD_0000, 32'h8000_0000, 32'h1234_5678}, 4'b0000);

    // Saturate the clip counter
    @(posedge clk); #1;
    mode = 3'd2; in_data = {4{32'h0007_0000}}; in_valid = 1'b1; out_ready = 1'b1;
    repeat (65540) @(posedge clk);
    #1; in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("sat_clip_count", clip_count, 16'hFFFF);

    // Clear together with a clipped handshake
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1; clr_count = 1'b1;
    @(negedge clk); check("clr_with_hs_valid", out_valid, 1'b1);
    @(posedge clk); #1; clr_count = 1'b0;
    @(negedge clk); check("clr_clip_count", clip_count, 16'd0);
    @(negedge clk); check("post_clr_clip_count", clip_count, 16'd1);
    drain("clr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
